// File: rtl/spi_cmd_pkg.sv
// Shared widths and FSM encoding for the SPI command deframer.
// Imported by spi_cmd_deframer and its bench-facing top level.
package spi_cmd_pkg;

   localparam int CMD_WIDTH      = 8;
   localparam int DATAWORD_WIDTH = 16;
   localparam int FRAME_BITS     = CMD_WIDTH + DATAWORD_WIDTH;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an async pin with registered rise/fall strobes.
// Ports: clk, rst_n, d (async in), rise/fall (1-cycle strobes, clk domain).
module sync_edge_detect #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= {STAGES{RST_VAL}};
         prev <= RST_VAL;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         sync <= {sync[STAGES-2:0], d};
         prev <= sync[STAGES-1];
         rise <= sync[STAGES-1] & ~prev;
         fall <= ~sync[STAGES-1] & prev;
      end
   end

endmodule

// File: rtl/spi_cmd_deframer.sv
// SPI mode-0 target deframer: one {cmd, data} frame per CS_N window, oversampled in clk.
// Ports: clk, rst_n, spi_sck/cs_n/mosi in, spi_miso out, cmd_word, data_word, cmd_valid, frame_err.
// Optional MISO echo of the previous command byte: define SPI_MISO_ECHO_EN.
module spi_cmd_deframer
   import spi_cmd_pkg::*;
#(
   parameter int CMD_WIDTH      = spi_cmd_pkg::CMD_WIDTH,
   parameter int DATAWORD_WIDTH = spi_cmd_pkg::DATAWORD_WIDTH,
   parameter int SYNC_STAGES    = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      spi_sck,
   input  logic                      spi_cs_n,
   input  logic                      spi_mosi,
   output logic                      spi_miso,
   output logic [CMD_WIDTH-1:0]      cmd_word,
   output logic [DATAWORD_WIDTH-1:0] data_word,
   output logic                      cmd_valid,
   output logic                      frame_err
);

   localparam int FRAME_BITS = CMD_WIDTH + DATAWORD_WIDTH;
   localparam int CNT_W      = $clog2(FRAME_BITS + 1);

   logic sck_rise, sck_fall, cs_rise, cs_fall;
   logic [SYNC_STAGES:0] mosi_sync;
   logic                 mosi_s;

   sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (spi_sck),
      .rise (sck_rise),
      .fall (sck_fall)
   );

   // cs_n resets high so releasing reset with CS idle gives no edge
   sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (spi_cs_n),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   // Extra last stage mirrors the strobe register so data lines up with sck_rise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) mosi_sync <= '0;
      else        mosi_sync <= {mosi_sync[SYNC_STAGES-1:0], spi_mosi};
   end
   assign mosi_s = mosi_sync[SYNC_STAGES];

   state_t                  state, state_n;
   logic [CNT_W-1:0]        bit_cnt, bit_cnt_n;
   logic [FRAME_BITS-2:0]   shreg, shreg_n;
   logic                    overrun, overrun_n;
   logic                    load, err;
   logic [FRAME_BITS-1:0]   frame;

   assign frame = {shreg, mosi_s};

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      overrun_n = overrun;
      load      = 1'b0;
      err       = 1'b0;
      unique case (state)
         IDLE: begin
            if (cs_fall) begin
               state_n   = SHIFT;
               bit_cnt_n = '0;
               overrun_n = 1'b0;
            end
         end
         SHIFT: begin
            // SCK edge is handled before a coincident CS rise
            if (sck_rise) begin
               shreg_n = frame[FRAME_BITS-2:0];
               if (bit_cnt != CNT_W'(FRAME_BITS))
                  bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
                  load    = 1'b1;
                  state_n = DONE;
               end
            end
            if (cs_rise) begin
               state_n = IDLE;
               err     = !load && (bit_cnt_n != '0);
            end
         end
         DONE: begin
            if (sck_rise) overrun_n = 1'b1;
            if (cs_rise) begin
               state_n = IDLE;
               err     = overrun_n;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         overrun   <= 1'b0;
         cmd_word  <= '0;
         data_word <= '0;
         cmd_valid <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         overrun   <= overrun_n;
         cmd_valid <= load;
         frame_err <= err;
         if (load) begin
            cmd_word  <= frame[FRAME_BITS-1 -: CMD_WIDTH];
            data_word <= frame[DATAWORD_WIDTH-1:0];
         end
      end
   end

`ifdef SPI_MISO_ECHO_EN
   // Echo the previous command byte; zeros shift in behind it
   logic [CMD_WIDTH-1:0] tx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tx <= '0;
      else if (state == IDLE && cs_fall)
         tx <= cmd_word;
      else if (state == SHIFT && sck_fall)
         tx <= {tx[CMD_WIDTH-2:0], 1'b0};
   end

   always_comb begin
      spi_miso = 1'b0;
      if (state == IDLE && cs_fall) spi_miso = cmd_word[CMD_WIDTH-1];
      else if (state == SHIFT)      spi_miso = tx[CMD_WIDTH-1];
   end
`else
   logic unused_sck_fall;
   assign unused_sck_fall = sck_fall;
   assign spi_miso        = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_deframer.sv
// Scoreboard bench for spi_cmd_deframer: directed frames, queued expectations.
// Monitor pops one expectation per cmd_valid/frame_err strobe.
module tb_spi_cmd_deframer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        spi_sck, spi_cs_n, spi_mosi, spi_miso;
   logic [7:0]  cmd_word;
   logic [15:0] data_word;
   logic        cmd_valid, frame_err;

   typedef struct {
      logic [1:0]  strb;
      logic [7:0]  c;
      logic [15:0] d;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [23:0] miso_cap;

   spi_cmd_deframer dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi_sck  (spi_sck),
      .spi_cs_n (spi_cs_n),
      .spi_mosi (spi_mosi),
      .spi_miso (spi_miso),
      .cmd_word (cmd_word),
      .data_word(data_word),
      .cmd_valid(cmd_valid),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] s, input logic [7:0] c,
                       input logic [15:0] d);
      exp_t e;
      e.strb = s;
      e.c    = c;
      e.d    = d;
      exp_q.push_back(e);
   endtask

   // f_sck = f_clk/8: 40 ns half period with a 10 ns clk
   task automatic send(input logic [7:0] c, input logic [15:0] d,
                       input int nbits, input bit raise_cs);
      logic [23:0] f;
      f        = {c, d};
      miso_cap = '0;
      spi_cs_n = 1'b0;
      #80;
      for (int i = 0; i < nbits; i++) begin
         spi_mosi = (i < 24) ? f[23-i] : 1'b1;
         #40;
         miso_cap = {miso_cap[22:0], spi_miso};
         spi_sck  = 1'b1;
         #40;
         spi_sck  = 1'b0;
      end
      #80;
      if (raise_cs) spi_cs_n = 1'b1;
      #160;
   endtask

   always @(negedge clk) begin
      if (rst_n && (cmd_valid || frame_err)) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_strobe", {30'd0, cmd_valid, frame_err}, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("strobe_kind", {30'd0, cmd_valid, frame_err}, {30'd0, e.strb});
            chk("cmd_word", {24'd0, cmd_word}, {24'd0, e.c});
            chk("data_word", {16'd0, data_word}, {16'd0, e.d});
         end
      end
   end

   initial begin
      #200_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      spi_sck  = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      #32;
      chk("rst_cmd", {24'd0, cmd_word}, 32'd0);
      chk("rst_data", {16'd0, data_word}, 32'd0);
      chk("rst_valid", {31'd0, cmd_valid}, 32'd0);
      chk("rst_err", {31'd0, frame_err}, 32'd0);
      chk("rst_miso", {31'd0, spi_miso}, 32'd0);
      rst_n = 1'b1;
      #40;

      push(2'b10, 8'h22, 16'h1234);
      send(8'h22, 16'h1234, 24, 1'b1);
`ifndef SPI_MISO_ECHO_EN
      chk("miso_tied", {8'd0, miso_cap}, 32'd0);
`endif

      push(2'b10, 8'hA5, 16'hBEEF);
      send(8'hA5, 16'hBEEF, 24, 1'b1);
      push(2'b10, 8'h01, 16'h0000);
      send(8'h01, 16'h0000, 24, 1'b1);

      push(2'b01, 8'h01, 16'h0000);
      send(8'hFF, 16'hFFFF, 10, 1'b1);

      push(2'b10, 8'h3C, 16'h5555);
      push(2'b01, 8'h3C, 16'h5555);
      send(8'h3C, 16'h5555, 25, 1'b1);

      send(8'h77, 16'h7777, 12, 1'b0);
      rst_n = 1'b0;
      #20;
      rst_n = 1'b1;
      #20;
      chk("midrst_cmd", {24'd0, cmd_word}, 32'd0);
      chk("midrst_data", {16'd0, data_word}, 32'd0);
      spi_cs_n = 1'b1;
      #160;
      push(2'b10, 8'h80, 16'h0007);
      send(8'h80, 16'h0007, 24, 1'b1);

`ifdef SPI_MISO_ECHO_EN
      push(2'b10, 8'h55, 16'h1111);
      send(8'h55, 16'h1111, 24, 1'b1);
      chk("miso_echo_80", {8'd0, miso_cap}, 32'h0080_0000);
      push(2'b10, 8'hC3, 16'h2222);
      send(8'hC3, 16'h2222, 24, 1'b1);
      chk("miso_echo_55", {8'd0, miso_cap}, 32'h0055_0000);
`endif

      for (int i = 0; i < 50; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("queue_drained", exp_q.size(), 32'd0);
      chk("final_cmd", {24'd0, cmd_word}, 32'h80);
      chk("final_data", {16'd0, data_word}, 32'h0007);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
